// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a byte FIFO over a valid/ready interface.
// The line and busy outputs are registered from the state, so they lag the state machine by one cycle.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 200000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk_200MHz,
  input  logic                        rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end
  endgenerate

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          baud_done;
  logic          push;
  logic          pop;
  logic          line_nxt;

  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign push       = tx_valid & tx_ready;
  // Pop from IDLE, or on the STOP completion edge so frames run back-to-back.
  assign pop        = (count != '0) && ((state == ST_IDLE) || ((state == ST_STOP) && baud_done));
  assign fifo_count = count;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_200MHz) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk_200MHz or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      tx_ready <= (count_nxt != FULL_COUNT);
    end
  end

  always_ff @(posedge clk_200MHz or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    line_nxt = 1'b1;
    case (state)
      ST_START: line_nxt = 1'b0;
      ST_DATA:  line_nxt = shift[0];
      default:  line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_200MHz or posedge rst) begin
    if (rst) begin
      uart_txd <= 1'b1;
      busy     <= 1'b0;
    end else begin
      uart_txd <= line_nxt;
      busy     <= (state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model of queue and line timing, plus a UART decoder.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int C     = 10;
  localparam int CB    = 1736;
  localparam int DEPTH = 16;

  logic       clk_200MHz = 1'b0;
  logic       rst        = 1'b1;
  logic [7:0] tx_data    = '0;
  logic       tx_valid   = 1'b0;
  logic       tx_ready;
  logic       uart_txd;
  logic       busy;
  logic [4:0] fifo_count;

  logic [7:0] big_data  = '0;
  logic       big_valid = 1'b0;
  logic       big_ready;
  logic       big_txd;
  logic       big_busy;
  logic [4:0] big_count;

  always #5 clk_200MHz = ~clk_200MHz;

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk_200MHz(clk_200MHz), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_txd(uart_txd), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(.CLK_FREQ(200000000), .BAUD_RATE(115200), .FIFO_DEPTH(DEPTH)) u_dut_big (
    .clk_200MHz(clk_200MHz), .rst(rst), .tx_data(big_data), .tx_valid(big_valid),
    .tx_ready(big_ready), .uart_txd(big_txd), .busy(big_busy), .fifo_count(big_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Each accepted byte: the edge it was pushed, the edge it leaves the queue, its value.
  typedef struct {
    int         push_e;
    int         pop_e;
    logic [7:0] b;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] mon_q[$];
  int         last_pop = -100000;

  function automatic int model_count(input int e);
    int n = 0;
    foreach (mq[i]) if (mq[i].push_e <= e && mq[i].pop_e > e) n++;
    return n;
  endfunction

  // {busy, txd} after edge e: a frame popped at P occupies edges P+1 .. P+10*C.
  function automatic logic [1:0] model_line(input int e);
    logic [1:0] r = 2'b01;
    int k;
    foreach (mq[i]) begin
      if (e >= mq[i].pop_e + 1 && e <= mq[i].pop_e + 10 * C) begin
        k = (e - mq[i].pop_e - 1) / C;
        r[1] = 1'b1;
        if (k == 0)      r[0] = 1'b0;
        else if (k <= 8) r[0] = mq[i].b[k-1];
        else             r[0] = 1'b1;
      end
    end
    return r;
  endfunction

  always @(posedge clk_200MHz) begin : model_upd
    ent_t ne;
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      mon_q.delete();
      last_pop = -100000;
    end else begin
      while (mq.size() > 0 && mq[0].pop_e + 10 * C + 1 < cyc) void'(mq.pop_front());
      if (tx_valid && model_count(cyc - 1) != DEPTH) begin
        ne.push_e = cyc;
        ne.pop_e  = (cyc + 1 > last_pop + 10 * C) ? cyc + 1 : last_pop + 10 * C;
        ne.b      = tx_data;
        last_pop  = ne.pop_e;
        mq.push_back(ne);
        mon_q.push_back(tx_data);
      end
    end
  end

  always @(negedge clk_200MHz) begin : cycle_chk
    int         cnt;
    logic [1:0] bl;
    if (rst) begin
      cnt = 0;
      bl  = 2'b01;
    end else begin
      cnt = model_count(cyc);
      bl  = model_line(cyc);
    end
    check_eq("fifo_count", 32'(fifo_count), 32'(cnt));
    check_eq("tx_ready",   32'(tx_ready),   32'(cnt != DEPTH));
    check_eq("busy",       32'(busy),       32'(bl[1]));
    check_eq("uart_txd",   32'(uart_txd),   32'(bl[0]));
  end

  logic       dec_prev   = 1'b1;
  logic       dec_on     = 1'b0;
  int         dec_t      = 0;
  logic [7:0] dec_b      = '0;
  int         dec_frames = 0;

  always @(negedge clk_200MHz) begin
    if (rst) begin
      dec_on = 1'b0;
    end else if (!dec_on) begin
      if (dec_prev && !uart_txd) begin
        dec_on = 1'b1;
        dec_t  = 0;
      end
    end else begin
      dec_t++;
      if (dec_t == C / 2) begin
        check_eq("dec_start", 32'(uart_txd), 32'(0));
      end else if (dec_t > C / 2 && dec_t < C / 2 + 9 * C && (dec_t - C / 2) % C == 0) begin
        dec_b[(dec_t - C / 2) / C - 1] = uart_txd;
      end else if (dec_t == C / 2 + 9 * C) begin
        check_eq("dec_stop", 32'(uart_txd), 32'(1));
        dec_frames++;
        check_eq("dec_expected_frame", 32'(mon_q.size() != 0), 32'(1));
        if (mon_q.size() != 0) check_eq("dec_byte", 32'(dec_b), 32'(mon_q.pop_front()));
        dec_on = 1'b0;
      end
    end
    dec_prev = rst ? 1'b1 : uart_txd;
  end

  task automatic drain();
    for (int k = 0; k < 4000; k++) begin
      if (cyc > last_pop + 10 * C + 2) break;
      @(negedge clk_200MHz);
    end
    check_eq("drain_busy",  32'(busy),       32'(0));
    check_eq("drain_count", 32'(fifo_count), 32'(0));
  endtask

  initial begin
    int         n_edge;
    int         target;
    int         saved;
    string      msg;
    logic [9:0] fb;
    logic [7:0] got;
    logic [7:0] ch;

    repeat (3) @(negedge clk_200MHz);
    rst = 1'b0;
    repeat (200) @(negedge clk_200MHz);

    // single byte 'A'
    tx_valid = 1'b1; tx_data = 8'h41; n_edge = cyc + 1;
    @(negedge clk_200MHz);
    tx_valid = 1'b0;
    repeat (101) @(negedge clk_200MHz);
    check_eq("single_busy_hold", 32'(busy), 32'(1));
    @(negedge clk_200MHz);
    check_eq("single_busy_fall", 32'(busy), 32'(0));
    check_eq("single_frames", 32'(dec_frames), 32'(1));
    repeat (20) @(negedge clk_200MHz);

    // burst of 20 attempts: 17 accepted, the rest dropped on full
    saved = dec_frames;
    for (int i = 0; i < 20; i++) begin
      tx_valid = 1'b1; tx_data = 8'(i);
      @(negedge clk_200MHz);
    end
    tx_valid = 1'b0;
    check_eq("burst_full_count", 32'(fifo_count), 32'(16));
    check_eq("burst_full_ready", 32'(tx_ready),   32'(0));
    drain();
    check_eq("burst_frames", 32'(dec_frames - saved), 32'(17));

    // hold count at 3, push on the STOP completion edge
    n_edge = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_data = 8'(8'hA0 + i);
      @(negedge clk_200MHz);
    end
    tx_valid = 1'b0;
    target = n_edge + 1 + 10 * C;
    while (cyc < target - 1) @(negedge clk_200MHz);
    check_eq("simul_count_before", 32'(fifo_count), 32'(3));
    tx_valid = 1'b1; tx_data = 8'hA4;
    @(negedge clk_200MHz);
    tx_valid = 1'b0;
    check_eq("simul_count_after", 32'(fifo_count), 32'(3));
    drain();

    // reset in DATA bit 4 of 0x55 with 5 bytes queued
    n_edge = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1; tx_data = (i == 0) ? 8'h55 : 8'(i);
      @(negedge clk_200MHz);
    end
    tx_valid = 1'b0;
    target = n_edge + 1 + 5 * C + 4;
    while (cyc < target) @(negedge clk_200MHz);
    check_eq("rst_mid_queued", 32'(fifo_count), 32'(5));
    saved = dec_frames;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_txd",   32'(uart_txd),   32'(1));
    check_eq("rst_mid_count", 32'(fifo_count), 32'(0));
    check_eq("rst_mid_busy",  32'(busy),       32'(0));
    check_eq("rst_mid_ready", 32'(tx_ready),   32'(1));
    repeat (3) @(negedge clk_200MHz);
    rst = 1'b0;
    repeat (300) @(negedge clk_200MHz);
    check_eq("rst_mid_no_frames", 32'(dec_frames), 32'(saved));

    // randomized traffic: dense phase overruns the FIFO, sparse phase idles between frames
    for (int i = 0; i < 1200; i++) begin
      tx_valid = (i < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      tx_data  = 8'($urandom);
      @(negedge clk_200MHz);
    end
    tx_valid = 1'b0;
    drain();
    repeat (5) @(negedge clk_200MHz);
    check_eq("rand_all_decoded", 32'(mon_q.size()), 32'(0));

    // default parameters: "Hi\n"
    msg = "Hi\n";
    for (int i = 0; i < 3; i++) begin
      big_valid = 1'b1; big_data = msg[i];
      @(negedge clk_200MHz);
    end
    big_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!big_txd) break;
      @(negedge clk_200MHz);
    end
    check_eq("big_start_seen", 32'(big_txd), 32'(0));
    if (!big_txd) begin
      for (int f = 0; f < 3; f++) begin
        ch  = msg[f];
        fb  = {1'b1, ch, 1'b0};
        got = '0;
        for (int t = 0; t < 10 * CB; t++) begin
          if (t % CB == 0 || t % CB == CB - 1) check_eq("big_bit_edge", 32'(big_txd), 32'(fb[t / CB]));
          if (t % CB == CB / 2 && t / CB >= 1 && t / CB <= 8) got[t / CB - 1] = big_txd;
          @(negedge clk_200MHz);
        end
        $write("%c", got);
        check_eq("big_char", 32'(got), 32'(ch));
        if (f < 2) begin
          check_eq("big_back_to_back", 32'(big_txd), 32'(0));
        end else begin
          check_eq("big_idle_line", 32'(big_txd),  32'(1));
          check_eq("big_busy_end",  32'(big_busy), 32'(0));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
